// File: rtl/alu_mul_ctrl_pkg.sv
// Shared definitions for the shift-add multiplier controller.
// Holds the FSM state encoding and the ALU control word used for every
// accumulate step, so the top and the ALU agree on them from one place.
package alu_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Control word of the shared ALU:
  //   zx/zy zero an input, nx/ny invert it, f selects add (1) or and (0),
  //   no inverts the result.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  // x + y with no input or output conditioning.
  localparam alu_ctrl_t AluCtrlAdd = '{zx: 1'b0, nx: 1'b0, zy: 1'b0, ny: 1'b0,
                                       f: 1'b1, no: 1'b0};

endpackage

// File: rtl/alu_mul_ctrl_if.sv
// Request/result bundle of the multiplier controller.
//   start, a, b           : request and operands (driven by the requester)
//   busy, done, product,
//   zr, ng                : status and result (driven by the controller)
interface alu_mul_ctrl_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic             zr;
  logic             ng;

  modport master (
    output start, a, b,
    input  busy, done, product, zr, ng
  );

  modport slave (
    input  start, a, b,
    output busy, done, product, zr, ng
  );

endinterface

// File: rtl/alu_mul_ctrl_alu.sv
// Combinational ALU with zero/negate conditioning on both inputs, add/and
// function select and optional output inversion.
//   x_i, y_i : operands
//   ctrl_i   : control word (see alu_ctrl_t)
//   out_o    : result, carry out discarded
module alu_mul_ctrl_alu
  import alu_mul_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  alu_ctrl_t        ctrl_i,
  output logic [WIDTH-1:0] out_o
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z   = ctrl_i.zx ? '0 : x_i;
    x_n   = ctrl_i.nx ? ~x_z : x_z;
    y_z   = ctrl_i.zy ? '0 : y_i;
    y_n   = ctrl_i.ny ? ~y_z : y_z;
    res   = ctrl_i.f ? (x_n + y_n) : (x_n & y_n);
    out_o = ctrl_i.no ? ~res : res;
  end

endmodule

// File: rtl/alu_mul_ctrl.sv
// Fixed-latency shift-add multiplier controller.
// Accepts a start in IDLE, runs one shift-add step per clock for WIDTH
// steps (16 at the default width), then pulses done for one cycle with the
// low WIDTH bits of a*b on product. All additions go through the ALU.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : start/a/b in, busy/done/product/zr/ng out
module alu_mul_ctrl
  import alu_mul_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_mul_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] alu_sum;

  alu_mul_ctrl_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .x_i    (acc_q),
    .y_i    (mcand_q),
    .ctrl_i (AluCtrlAdd),
    .out_o  (alu_sum)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    product_d = product_q;
    count_d   = count_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          count_d  = '0;
          busy_d   = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        // Always WIDTH steps, even once the multiplier has shifted to zero.
        if (mplier_q[0]) acc_d = alu_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 1'b1;
        if (count_q == CntW'(WIDTH - 1)) begin
          // Last step: publish the accumulator including this step's add.
          product_d = mplier_q[0] ? alu_sum : acc_q;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign bus.zr      = (product_q == '0);
  assign bus.ng      = product_q[WIDTH-1];

endmodule

// File: doc/alu_mul_ctrl.md
ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/product width in bits.
REQ-002 SHALL have port: clock  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port: a  in  WIDTH  multiplicand, captured at acceptance.
REQ-006 SHALL have port: b  in  WIDTH  multiplier, captured at acceptance.
REQ-007 SHALL have port: busy  out  1  high while iterating (RUN).
REQ-008 SHALL have port: done  out  1  one-cycle pulse, product valid.
REQ-009 SHALL have port: product  out  WIDTH  low WIDTH bits of a*b, held until next acceptance.
REQ-010 SHALL have port: zr  out  1  product == 0.
REQ-011 SHALL have port: ng  out  1  product[WIDTH-1].

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1, RUN->DONE after 16 iterations, DONE->IDLE unconditionally.
REQ-013 SHALL, on acceptance edge E0 (IDLE, start=1), latch mcand<=a, mplier<=b, acc<=0, count<=0.
REQ-014 SHALL perform one shift-add iteration per edge E1..E16: if mplier[0], acc<=acc+mcand; mcand<=mcand<<1; mplier<=mplier>>1; count<=count+1.
REQ-015 SHALL compute every acc+mcand addition through the shared ALU with control zx=0,nx=0,zy=0,ny=0,f=1,no=0; no separate adder.
REQ-016 SHALL discard all carries and shifted-out bits; product is (a*b) mod 2^WIDTH.
REQ-017 SHALL run all 16 iterations regardless of operand values (fixed latency, no early exit).
REQ-018 SHALL drive busy=1 exactly from E0 to E16, done=1 exactly from E16 to E17, both 0 otherwise.
REQ-019 SHALL update product on E16 only; zr/ng derive combinationally from product.
REQ-020 SHALL ignore start while in RUN or DONE; operands are not re-latched.
REQ-021 SHALL accept a new start in the cycle directly after done (back-to-back, one idle cycle minimum).
REQ-022 SHALL keep product, zr, ng stable in IDLE irrespective of a, b changes.

Reset
REQ-023 SHALL, on reset_n=0, immediately force state=IDLE, busy=0, done=0, product=0, zr=1, ng=0, acc=0, count=0.
REQ-024 SHALL abandon an in-flight multiply on reset mid-RUN with no done pulse; first start after reset_n rises is accepted normally.

Structure
REQ-025 SHALL take state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the ALU add control word from a shared `include definitions file, not local literals.
REQ-026 SHALL instantiate the existing ALU as its single sub-module (x=acc, y=mcand); the iteration counter and shift registers are local.

Verification
REQ-027 SHALL verify a=3, b=5, start pulse -> busy 16 cycles, done one cycle, product=0x000F, zr=0, ng=0.
REQ-028 SHALL verify a=0xFFFF, b=0xFFFF -> product=0x0001; a=0x0100, b=0x0100 -> product=0x0000, zr=1 (wrap).
REQ-029 SHALL verify a=0x8000, b=1 -> product=0x8000, ng=1; a=0, b=0x1234 -> product=0, zr=1, still 16-cycle latency.
REQ-030 SHALL verify start held high with new a=7,b=7 during RUN of 3*5 -> result 0x000F, then re-accept gives 0x0031.
REQ-031 SHALL verify reset_n low at iteration 8 of 3*5 -> all outputs at reset values immediately, no done; subsequent 2*2 -> product=0x0004.
